// File: rtl/vga_frame_capture.sv
// Captures one VGA frame, or every frame in continuous mode, into a linear frame buffer.
// Optional resolution measurement is built when VGA_FRAME_CAPTURE_MEASURE_EN is defined.
module vga_frame_capture #(
    parameter int unsigned MAX_PIXELS = 307200
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        HS,
    input  logic        VS,
    input  logic        blank_n,
    input  logic [7:0]  r_data,
    input  logic [7:0]  g_data,
    input  logic [7:0]  b_data,
    input  logic        arm,
    input  logic        continuous,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic [10:0] h_active,
    output logic [9:0]  v_active
);

    localparam int unsigned AW = 19;
    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam logic [AW-1:0] PIX_LIMIT = AW'(MAX_PIXELS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_vs_q;
    logic [AW-1:0]   r_pix_cnt;
    logic            w_frame_start;
    logic            w_unused_hs;

    // Horizontal sync carries no information the capture needs.
    assign w_unused_hs   = HS;
    assign w_frame_start = r_vs_q & ~VS;

    // Capture FSM with registered write port and status outputs.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vs_q     <= 1'b1;
            r_pix_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_vs_q     <= VS;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state  <= S_ARMED;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_frame_start) begin
                        r_state   <= S_CAPTURE;
                        r_pix_cnt <= '0;
                        wr_addr   <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_frame_start) begin
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (blank_n) begin
                        if (r_pix_cnt < PIX_LIMIT) begin
                            wr_en     <= 1'b1;
                            wr_addr   <= r_pix_cnt;
                            wr_data   <= {b_data, g_data, r_data};
                            r_pix_cnt <= AW'(r_pix_cnt + 1'b1);
                        end else begin
                            // Buffer full: drop the pixel and pin the address.
                            overflow <= 1'b1;
                            wr_addr  <= LAST_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    if (continuous) begin
                        r_state   <= S_CAPTURE;
                        busy      <= 1'b1;
                        r_pix_cnt <= '0;
                        wr_addr   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VGA_FRAME_CAPTURE_MEASURE_EN
    logic            r_blank_q;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic            w_blank_rise;
    logic            w_blank_fall;
    logic [VW-1:0]   w_v_cnt_nxt;

    assign w_blank_rise = blank_n & ~r_blank_q;
    assign w_blank_fall = ~blank_n & r_blank_q;
    assign w_v_cnt_nxt  = (w_blank_fall && (r_v_cnt != {VW{1'b1}})) ?
                          VW'(r_v_cnt + 1'b1) : r_v_cnt;

    // Line length and line count, measured regardless of capture state.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_blank_q <= 1'b0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            h_active  <= '0;
            v_active  <= '0;
        end else begin
            r_blank_q <= blank_n;
            if (w_blank_rise) begin
                r_h_cnt <= HW'(1);
            end else if (blank_n && (r_h_cnt != {HW{1'b1}})) begin
                r_h_cnt <= HW'(r_h_cnt + 1'b1);
            end
            if (w_blank_fall) begin
                h_active <= r_h_cnt;
            end
            if (w_frame_start) begin
                v_active <= w_v_cnt_nxt;
                r_v_cnt  <= '0;
            end else begin
                r_v_cnt  <= w_v_cnt_nxt;
            end
        end
    end
`else
    assign h_active = '0;
    assign v_active = '0;
`endif

endmodule

// File: doc/vga_frame_capture.md
VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 SHALL provide port vga_clk, input, 1, pixel clock; all logic on its rising edge.
REQ-002 SHALL provide port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL provide ports HS and VS, input, 1 each, active-low sync pulses in vga_clk domain.
REQ-004 SHALL provide port blank_n, input, 1, high = active pixel.
REQ-005 SHALL provide ports r_data, g_data, b_data, input, 8 each, pixel colour.
REQ-006 SHALL provide port arm, input, 1, single-cycle request to capture the next full frame.
REQ-007 SHALL provide port continuous, input, 1, high = re-capture every frame without re-arming.
REQ-008 SHALL provide port wr_en, output, 1, frame-buffer write strobe.
REQ-009 SHALL provide port wr_addr, output, 19, frame-buffer word address.
REQ-010 SHALL provide port wr_data, output, 24, pixel packed {b,g,r}.
REQ-011 SHALL provide port busy, output, 1, high in ARMED or CAPTURE.
REQ-012 SHALL provide port frame_done, output, 1, one-cycle pulse at end of captured frame.
REQ-013 SHALL provide port overflow, output, 1, sticky: active pixels exceeded 307200 in a frame.
REQ-014 SHALL provide ports h_active (11) and v_active (10), outputs, measured resolution.

Function
REQ-015 SHALL detect frame start as VS falling edge: registered VS = 1, current VS = 0.
REQ-016 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-017 IDLE -> ARMED on arm = 1; VS edge in that same cycle SHALL NOT start capture.
REQ-018 ARMED -> CAPTURE on frame start; wr_addr counter cleared to 0 in that cycle.
REQ-019 CAPTURE -> DONE on next frame start; DONE lasts exactly one cycle, frame_done = 1 there.
REQ-020 DONE -> CAPTURE (counter cleared) if continuous = 1, else DONE -> IDLE.
REQ-021 arm in ARMED, CAPTURE or DONE SHALL be ignored.
REQ-022 In CAPTURE, each cycle with blank_n = 1 SHALL produce one write; wr_en, wr_addr, wr_data registered, one cycle after pixel sample.
REQ-023 wr_addr SHALL start at 0 per frame and increment by 1 per accepted pixel, no gaps.
REQ-024 Pixels beyond address 307199 SHALL be dropped (wr_en = 0), address held at 307199, overflow set.
REQ-025 overflow SHALL clear only on arm accepted in IDLE or on reset.
REQ-026 wr_en SHALL be 0 in IDLE, ARMED, DONE, and in CAPTURE when blank_n = 0.
REQ-027 Short frames (fewer active pixels) SHALL still end at the next frame start with frame_done.
REQ-028 busy SHALL be 1 in ARMED and CAPTURE, 0 otherwise.

Reset
REQ-029 Reset SHALL asynchronously force IDLE; wr_en, wr_addr, wr_data, frame_done, overflow, h_active, v_active, busy all 0; VS history register 1.
REQ-030 Reset mid-CAPTURE SHALL discard the frame without frame_done; deassertion returns to IDLE.

Configuration
REQ-031 Macro VGA_FRAME_CAPTURE_MEASURE_EN SHALL gate resolution measurement.
REQ-032 With macro: count active pixels per line (reset at blank_n rising) and lines per frame (blank_n falling edges); h_active latched at each blank_n falling, v_active latched at every frame start, in all states; saturate at 2047 / 1023.
REQ-033 Without macro: h_active and v_active SHALL be constant 0 and measurement counters absent.

Verification
REQ-034 640x480 timing, arm in IDLE -> first write wr_addr 0 one cycle after first active pixel; last write 307199; frame_done one cycle at next VS falling; busy drops.
REQ-035 arm same cycle as VS falling -> ARMED only; capture starts one frame later.
REQ-036 continuous = 1 over 3 frames -> 3 frame_done pulses, wr_addr restarts at 0 each frame.
REQ-037 Frame with 640x481 active -> 307200 writes, 640 dropped, overflow = 1 until next arm.
REQ-038 Reset asserted mid-line in CAPTURE -> outputs 0 immediately, no frame_done, IDLE after release.
REQ-039 Macro defined, 800x600 timing -> h_active = 800, v_active = 600 after second frame start; undefined -> both 0.
